split: RTL and testbench

SPLIT -- requirements
Module: split

---
 rtl/split.sv | 114 +++++++++++
 tb/tb_split.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/split.sv
// ============================================================================
// Module   : split
// Purpose  : Steers payload A into one of two 2-entry output FIFOs (L or R) by control C.
// Revision : 1.0
// ============================================================================
`default_nettype none

module split_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // push+pop together leaves the count untouched
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module split #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_data,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic             C_data,
  input  logic             C_valid,
  output logic             C_ready,
  output logic [WIDTH-1:0] L_data,
  output logic             L_valid,
  input  logic             L_ready,
  output logic [WIDTH-1:0] R_data,
  output logic             R_valid,
  input  logic             R_ready,
  output logic [1:0]       L_count,
  output logic [1:0]       R_count
);

  logic fire;
  logic push_l;
  logic push_r;

  // Acceptance looks only at occupancy, never at the output ready of the
  // same buffer, so a full buffer waits one cycle after it drains.
  assign fire    = reset && A_valid && C_valid &&
                   (C_data ? (R_count != 2'd2) : (L_count != 2'd2));
  assign A_ready = fire;
  assign C_ready = fire;
  assign push_l  = fire && !C_data;
  assign push_r  = fire &&  C_data;

  split_buf #(.WIDTH(WIDTH)) u_buf_l (
    .clk       (clk),
    .reset     (reset),
    .push      (push_l),
    .in_data   (A_data),
    .out_ready (L_ready),
    .out_data  (L_data),
    .out_valid (L_valid),
    .count     (L_count)
  );

  split_buf #(.WIDTH(WIDTH)) u_buf_r (
    .clk       (clk),
    .reset     (reset),
    .push      (push_r),
    .in_data   (A_data),
    .out_ready (R_ready),
    .out_data  (R_data),
    .out_valid (R_valid),
    .count     (R_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_split.sv
// Scoreboard bench for split: stimulus queues expected outputs, a monitor pops and compares.
`default_nettype none

module tb_split;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] A_data = '0;
  logic             A_valid = 1'b0;
  logic             A_ready;
  logic             C_data = 1'b0;
  logic             C_valid = 1'b0;
  logic             C_ready;
  logic [WIDTH-1:0] L_data;
  logic             L_valid;
  logic             L_ready = 1'b0;
  logic [WIDTH-1:0] R_data;
  logic             R_valid;
  logic             R_ready = 1'b0;
  logic [1:0]       L_count;
  logic [1:0]       R_count;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] q_l [$];
  logic [WIDTH-1:0] q_r [$];

  split #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready),
    .C_data(C_data), .C_valid(C_valid), .C_ready(C_ready),
    .L_data(L_data), .L_valid(L_valid), .L_ready(L_ready),
    .R_data(R_data), .R_valid(R_valid), .R_ready(R_ready),
    .L_count(L_count), .R_count(R_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Steering control must be a known value whenever it is offered
  always @(posedge clk) begin
    if (reset && C_valid) begin
      assert (!$isunknown(C_data)) else $error("C_data unknown while C_valid high");
    end
  end

  // Monitor: every output transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (reset) begin
      if (L_valid && L_ready) begin
        if (q_l.size() == 0) check("L_unexpected", L_data, '1 ^ L_data);
        else check("L_data", L_data, q_l.pop_front());
      end
      if (R_valid && R_ready) begin
        if (q_r.size() == 0) check("R_unexpected", R_data, '1 ^ R_data);
        else check("R_data", R_data, q_r.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic c);
    int n;
    A_data = d; C_data = c; A_valid = 1'b1; C_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (A_ready) begin
        if (c) q_r.push_back(d); else q_l.push_back(d);
        break;
      end
      n++;
      if (n > 20) begin
        check("send_timeout", {63'd0, A_ready}, 64'd1);
        break;
      end
    end
    tick();
    A_valid = 1'b0; C_valid = 1'b0;
  endtask

  initial begin
    // reset state, with both valids offered
    #2;
    A_valid = 1'b1; C_valid = 1'b1;
    #1;
    check("rst_A_ready", A_ready, 0);
    check("rst_C_ready", C_ready, 0);
    check("rst_L_count", L_count, 0);
    check("rst_R_count", R_count, 0);
    check("rst_L_valid", L_valid, 0);
    check("rst_R_valid", R_valid, 0);
    A_valid = 1'b0; C_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // steering
    L_ready = 1'b1; R_ready = 1'b1;
    send(64'h11, 1'b0);
    check("steer_L_valid", L_valid, 1);
    check("steer_L_data", L_data, 64'h11);
    send(64'h22, 1'b1);
    check("steer_R_valid", R_valid, 1);
    check("steer_R_data", R_data, 64'h22);
    check("steer_L_drained", L_count, 0);
    tick();
    check("steer_R_drained", R_count, 0);

    // fill and block
    L_ready = 1'b0;
    send(64'hA1, 1'b0);
    send(64'hA2, 1'b0);
    check("fill_L_count", L_count, 2);
    A_data = 64'hA3; C_data = 1'b0; A_valid = 1'b1; C_valid = 1'b1;
    #1;
    check("fill_A_ready_blocked", A_ready, 0);
    check("fill_C_ready_blocked", C_ready, 0);
    tick();
    L_ready = 1'b1;
    #1;
    check("full_pop_no_accept", A_ready, 0);
    tick();
    check("drain_L_count1", L_count, 1);
    check("drain_A_ready", A_ready, 1);
    q_l.push_back(64'hA3);
    tick();
    A_valid = 1'b0; C_valid = 1'b0;
    check("drain_pushpop_count", L_count, 1);
    check("drain_L_data_A3", L_data, 64'hA3);
    tick();
    check("drain_empty", L_count, 0);

    // independence
    L_ready = 1'b0; R_ready = 1'b0;
    send(64'hD1, 1'b0);
    send(64'hD2, 1'b0);
    send(64'hB1, 1'b1);
    check("indep_R_data", R_data, 64'hB1);
    check("indep_R_count", R_count, 1);
    check("indep_L_count", L_count, 2);
    check("indep_L_data", L_data, 64'hD1);
    L_ready = 1'b1; R_ready = 1'b1;
    tick(); tick(); tick();
    check("indep_L_empty", L_count, 0);
    check("indep_R_empty", R_count, 0);

    // simultaneous push and pop
    L_ready = 1'b0;
    send(64'hC1, 1'b0);
    L_ready = 1'b1;
    A_data = 64'hC2; C_data = 1'b0; A_valid = 1'b1; C_valid = 1'b1;
    #1;
    check("pp_A_ready", A_ready, 1);
    check("pp_L_data_C1", L_data, 64'hC1);
    q_l.push_back(64'hC2);
    tick();
    A_valid = 1'b0; C_valid = 1'b0;
    check("pp_L_count", L_count, 1);
    check("pp_L_data_C2", L_data, 64'hC2);
    tick();
    check("pp_L_empty", L_count, 0);

    // partial handshake
    R_ready = 1'b0;
    A_data = 64'hE1; C_data = 1'b1; A_valid = 1'b1; C_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("partial_A_ready", A_ready, 0);
      check("partial_C_ready", C_ready, 0);
      tick();
    end
    check("partial_R_count", R_count, 0);
    check("partial_L_count", L_count, 0);
    C_valid = 1'b1;
    #1;
    check("partial_accept", C_ready, 1);
    q_r.push_back(64'hE1);
    tick();
    A_valid = 1'b0; C_valid = 1'b0;
    check("partial_single", R_count, 1);
    R_ready = 1'b1;
    tick();
    check("partial_R_empty", R_count, 0);

    // reset mid-stream
    L_ready = 1'b0; R_ready = 1'b0;
    send(64'hF1, 1'b0);
    send(64'hF2, 1'b0);
    send(64'hF3, 1'b1);
    send(64'hF4, 1'b1);
    check("mid_L_full", L_count, 2);
    check("mid_R_full", R_count, 2);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_L_count", L_count, 0);
    check("mid_rst_R_count", R_count, 0);
    check("mid_rst_L_valid", L_valid, 0);
    check("mid_rst_R_valid", R_valid, 0);
    q_l.delete();
    q_r.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    L_ready = 1'b1; R_ready = 1'b1;
    send(64'h55, 1'b0);
    check("post_rst_L_data", L_data, 64'h55);
    check("post_rst_L_count", L_count, 1);
    tick(); tick();
    check("end_L_empty", L_count, 0);
    check("end_R_empty", R_count, 0);
    check("end_scoreboard", 64'(q_l.size() + q_r.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
